// File: rtl/ascon_stream_ctrl.sv
// rtl/ascon_stream_ctrl.sv - host/core word sequencer with ciphertext FIFO and tag latch
// Feeds one AD word plus PT_BLOCKS plaintext words to an ASCON128 core, collects ciphertext and tag.
module ascon_stream_ctrl #(
  parameter int PT_BLOCKS = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  output logic         busy_o,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [63:0]  in_data_i,
  output logic         core_start_o,
  output logic         core_data_valid_o,
  output logic [63:0]  core_data_o,
  input  logic         core_data_req_i,
  input  logic         core_cipher_valid_i,
  input  logic [63:0]  core_cipher_i,
  input  logic         core_end_i,
  input  logic [127:0] core_tag_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [63:0]  out_data_o,
  output logic         out_last_o,
  output logic         tag_valid_o,
  output logic [127:0] tag_o,
  output logic         done_o,
  output logic         err_o
);
  localparam int CW = $clog2(PT_BLOCKS + 1);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int NW = $clog2(OUT_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(PT_BLOCKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(PT_BLOCKS - 1);
  localparam logic [PW-1:0] PTR_MAX  = PW'(OUT_DEPTH - 1);
  localparam logic [NW-1:0] OCC_FULL = NW'(OUT_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    FEED,
    WAIT_END,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wc_q, wc_d;
  logic [CW-1:0] cc_q, cc_d;
  logic          cv_q;
  logic          end_q;
  logic          err_q, err_d;
  logic          tag_valid_q, tag_valid_d;
  logic [127:0]  tag_q, tag_d;

  logic [64:0]   mem_q [OUT_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [NW-1:0] occ_q;

  logic start_go;
  logic xfer;
  logic cipher_rise;
  logic end_rise;
  logic capture;
  logic push_req;
  logic push;
  logic pop;
  logic fifo_full;
  logic tag_load;
  logic drained;

  assign start_go    = (state_q == IDLE) & start_i;
  assign xfer        = in_ready_o;
  assign cipher_rise = core_cipher_valid_i & ~cv_q;
  assign end_rise    = core_end_i & ~end_q;
  assign capture     = (state_q != IDLE) & cipher_rise;
  assign push_req    = capture & (cc_q < CNT_MAX);
  assign fifo_full   = (occ_q == OCC_FULL);
  assign pop         = out_valid_o & out_ready_i;
  assign push        = push_req & (~fifo_full | pop);
  assign tag_load    = end_rise & ((state_q == FEED) | (state_q == WAIT_END));
  // A word landing this cycle keeps the message open even if the last one is leaving.
  assign drained     = ((occ_q == '0) | ((occ_q == NW'(1)) & pop)) & ~push;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start_i) state_d = START;
      START:    state_d = FEED;
      FEED: begin
        if (end_rise) begin
          state_d = DRAIN;
        end else if (xfer && (wc_q == CNT_MAX)) begin
          state_d = WAIT_END;
        end
      end
      WAIT_END: if (end_rise) state_d = DRAIN;
      DRAIN:    if (drained) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o            = (state_q != IDLE);
    core_start_o      = (state_q == START);
    core_data_valid_o = 1'b0;
    core_data_o       = '0;
    in_ready_o        = 1'b0;
    done_o            = 1'b0;
    if (state_q == FEED) begin
      core_data_valid_o = in_valid_i;
      core_data_o       = in_data_i;
      in_ready_o        = core_data_req_i & in_valid_i;
    end
    if (state_q == DRAIN) begin
      done_o = drained;
    end
  end

  always_comb begin
    wc_d        = wc_q;
    cc_d        = cc_q;
    err_d       = err_q;
    tag_valid_d = tag_valid_q;
    tag_d       = tag_q;
    if (start_go) begin
      wc_d        = '0;
      cc_d        = '0;
      err_d       = 1'b0;
      tag_valid_d = 1'b0;
    end else begin
      if (xfer) begin
        wc_d = wc_q + CW'(1);
      end
      if (push_req) begin
        cc_d = cc_q + CW'(1);
      end
      if ((core_data_req_i & ~core_data_valid_o) |
          (capture & (cc_q == CNT_MAX)) |
          (push_req & fifo_full & ~pop) |
          (end_rise & (state_q == FEED))) begin
        err_d = 1'b1;
      end
      if (tag_load) begin
        tag_d       = core_tag_i;
        tag_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wc_q        <= '0;
      cc_q        <= '0;
      cv_q        <= 1'b0;
      end_q       <= 1'b0;
      err_q       <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_q       <= '0;
    end else begin
      wc_q        <= wc_d;
      cc_q        <= cc_d;
      cv_q        <= core_cipher_valid_i;
      end_q       <= core_end_i;
      err_q       <= err_d;
      tag_valid_q <= tag_valid_d;
      tag_q       <= tag_d;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        occ_q <= occ_q + NW'(1);
      end else if (pop && !push) begin
        occ_q <= occ_q - NW'(1);
      end
    end
  end

  // Entry storage needs no reset: the head is masked by the occupancy count.
  always_ff @(posedge clock_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {(cc_q == CNT_LAST), core_cipher_i};
    end
  end

  assign out_valid_o = (occ_q != '0);
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q][63:0] : '0;
  assign out_last_o  = out_valid_o & mem_q[rd_ptr_q][64];
  assign tag_valid_o = tag_valid_q;
  assign tag_o       = tag_q;
  assign err_o       = err_q;

endmodule

// File: doc/ascon_stream_ctrl.md
# ascon_stream_ctrl

Stream-side controller that sequences one ASCON128 encryption core per message. It accepts a 64-bit word stream from the host (1 associated-data word, then PT_BLOCKS plaintext words) and forwards each word to the core on the core's consume handshake. It captures one ciphertext word per core cipher-valid window into an output FIFO with backpressure, then latches the 128-bit tag. It sits between the host bus adapter and the ASCON core top.

## Interface

Parameters:
- PT_BLOCKS, 4: plaintext words per message; also the ciphertext words captured per message.
- OUT_DEPTH, 4: output FIFO depth. Must be ≥ PT_BLOCKS.

Ports:
- clock_i  in  1  clock; all logic on its rising edge.
- resetb_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  begin a message; sampled only in IDLE.
- busy_o  out  1  high in every state except IDLE.
- in_valid_i  in  1  host word valid.
- in_ready_o  out  1  host word accepted this cycle.
- in_data_i  in  64  host word: word 0 = AD, words 1..PT_BLOCKS = plaintext.
- core_start_o  out  1  one-cycle start pulse to the core.
- core_data_valid_o  out  1  core_data_o holds a valid word.
- core_data_o  out  64  word presented to the core.
- core_data_req_i  in  1  core consumes core_data_o this cycle.
- core_cipher_valid_i  in  1  core cipher window (level, multi-cycle).
- core_cipher_i  in  64  core ciphertext.
- core_end_i  in  1  core finished, tag valid (level).
- core_tag_i  in  128  core tag.
- out_valid_o  out  1  ciphertext FIFO head valid.
- out_ready_i  in  1  host pops the head.
- out_data_o  out  64  FIFO head.
- out_last_o  out  1  head is ciphertext word PT_BLOCKS-1.
- tag_valid_o  out  1  tag_o valid; held until the next start.
- tag_o  out  128  captured tag.
- done_o  out  1  one-cycle pulse when the message is fully drained.
- err_o  out  1  sticky protocol error; cleared at start.

## Operation

- States: IDLE, START, FEED, WAIT_END, DRAIN.
- IDLE:
  - On start_i=1: clear word counter wc, cipher counter cc, tag_valid_o and err_o, then go to START.
  - start_i in any other state is ignored.
- START: core_start_o=1 for exactly this one cycle, then go to FEED.
- FEED:
  - core_data_o=in_data_i and core_data_valid_o=in_valid_i, both combinational.
  - in_ready_o = core_data_req_i & in_valid_i.
  - Each transfer increments wc. The transfer with wc==PT_BLOCKS goes to WAIT_END.
  - Outside FEED, in_ready_o=0 and core_data_valid_o=0.
- WAIT_END: rising edge of core_end_i latches tag_o←core_tag_i and sets tag_valid_o (visible next cycle), then go to DRAIN.
- DRAIN: when the FIFO is empty and no push occurs this cycle, pulse done_o and go to IDLE.
- Cipher capture, in any state except IDLE:
  - cv_q is core_cipher_valid_i registered.
  - Rising edge (core_cipher_valid_i & !cv_q) with cc<PT_BLOCKS: push core_cipher_i, tagged last if cc==PT_BLOCKS-1; cc++.
- Errors (each sets err_o, sticky):
  - core_data_req_i=1 while core_data_valid_o=0 (no transfer occurs).
  - Rising cipher edge with cc==PT_BLOCKS (word dropped).
  - Push with the FIFO full and no pop in the same cycle (word dropped).
  - Rising core_end_i in FEED: also latch the tag and go directly to DRAIN.
- FIFO: simultaneous push and pop is legal at any occupancy, including full. Pointers wrap modulo OUT_DEPTH.

## Timing

- Reset values:
  - State IDLE; all counters and cv_q = 0.
  - busy_o, core_start_o, core_data_valid_o, in_ready_o, out_valid_o, out_last_o, tag_valid_o, done_o, err_o = 0.
  - tag_o=0, core_data_o=0 (IDLE).
- Reset mid-message: returns to IDLE immediately and discards FIFO contents. The core shares resetb_i.
- start_i at cycle t gives core_start_o at t+1; FEED is entered at t+2.
- Host-to-core path is zero latency (combinational).
- Capture latency: rising cipher edge at t gives out_valid_o at t+1. Rising core_end_i at t gives tag_valid_o at t+1.
- out_data_o and out_valid_o hold stable while out_ready_i=0.
- done_o fires in the cycle the last pop empties the FIFO, or the cycle after DRAIN entry if the FIFO is already empty.

## Test plan

- Nominal, PT_BLOCKS=4, out_ready_i=1, core model: send AD=0x0001, PT=0x10..0x13 → core sees 5 words in order; 4 ciphertext words out, out_last_o on the 4th; tag_valid_o=1; one done_o pulse; err_o=0.
- Backpressure: out_ready_i=0 until WAIT_END → FIFO fills to 4 with no drop; release gives 4 pops in order, then done_o.
- Host stall: in_valid_i=0 for 10 cycles mid-FEED while core_data_req_i stays low → no transfer, wc unchanged; resumes correctly.
- Multi-cycle cipher window: core_cipher_valid_i high for 4 cycles → exactly one push per window.
- Protocol errors: a 5th cipher edge, or core_data_req_i with in_valid_i=0 → err_o=1 sticky and no extra push; the next start clears err_o.
- Reset during FEED after 2 words → all outputs at reset values next cycle; a fresh message then completes normally.
